// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: ALU operation codes and register-file constants.
package rv32i_pkg;

    // Width of the ALU operation code carried from decode to the ALU.
    localparam int ALU_CTRL_W = 3;

    // ALU operation codes understood by the ALU. Every other code is illegal.
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR = 3'b100;

    // Index of the hard-wired zero register. It is never a forwarding target.
    localparam int REG_X0 = 0;

    // True when the code is not one of the operations the ALU implements.
    function automatic logic alu_code_illegal(input logic [ALU_CTRL_W-1:0] code);
        return !(code inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR});
    endfunction

endpackage : rv32i_pkg

// File: rtl/fwd_mux.sv
// Operand forwarding for one source register. A MEM hit beats a WB hit, which
// beats the value read from the register file. x0 never matches.
module fwd_mux
    import rv32i_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs_addr_i,
    input  logic [WIDTH-1:0]      rs_data_i,
    input  logic                  mem_regWrite_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr_i,
    input  logic [WIDTH-1:0]      mem_result_i,
    input  logic                  wb_regWrite_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr_i,
    input  logic [WIDTH-1:0]      wb_result_i,
    output logic [WIDTH-1:0]      data_o
);

    localparam logic [REG_ADDR_W-1:0] X0_ADDR = REG_ADDR_W'(REG_X0);

    logic mem_hit;
    logic wb_hit;

    // Detect which later stage, if any, is about to write this source register.
    always_comb begin
        mem_hit = mem_regWrite_i && (mem_rd_addr_i != X0_ADDR) && (mem_rd_addr_i == rs_addr_i);
        wb_hit  = wb_regWrite_i  && (wb_rd_addr_i  != X0_ADDR) && (wb_rd_addr_i  == rs_addr_i);
    end

    // Priority select: the youngest producer (MEM) holds the most recent value.
    always_comb begin
        // NOTE: assigning a default first means every path drives data_o, so no latch is inferred.
        data_o = rs_data_i;
        if (mem_hit) begin
            data_o = mem_result_i;
        end else if (wb_hit) begin
            data_o = wb_result_i;
        end
    end

endmodule : fwd_mux

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register in front of the ALU. Captures decoded fields, resolves
// MEM/WB forwarding for both sources, and selects the ALU operands. Operand data
// keeps being refreshed from the forwarding network while the stage is stalled,
// so a result retiring from WB during the stall is not lost.
module alu_operand_stage
    import rv32i_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    // Decode-side inputs
    input  logic                  id_valid_i,
    input  logic [WIDTH-1:0]      id_pc_i,
    input  logic [WIDTH-1:0]      id_rs1_data_i,
    input  logic [WIDTH-1:0]      id_rs2_data_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
    input  logic [WIDTH-1:0]      id_imm_i,
    input  logic [ALU_CTRL_W-1:0] id_ALUControl_i,
    input  logic                  id_aluSrcA_i,
    input  logic                  id_aluSrcB_i,
    input  logic                  id_regWrite_i,

    // Pipeline control
    input  logic                  stall_i,
    input  logic                  flush_i,

    // Forwarding sources
    input  logic                  mem_regWrite_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr_i,
    input  logic [WIDTH-1:0]      mem_result_i,
    input  logic                  wb_regWrite_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr_i,
    input  logic [WIDTH-1:0]      wb_result_i,

    // Execute-side outputs
    output logic                  ex_valid_o,
    output logic [ALU_CTRL_W-1:0] ALUControl_o,
    output logic [WIDTH-1:0]      srcA_o,
    output logic [WIDTH-1:0]      srcB_o,
    output logic [WIDTH-1:0]      ex_storeData_o,
    output logic [REG_ADDR_W-1:0] ex_rd_addr_o,
    output logic                  ex_regWrite_o,
    output logic [WIDTH-1:0]      ex_pc_o,
    output logic                  illegal_o
);

    // Stage registers and their next-state values
    logic                  valid_q,      valid_d;
    logic [WIDTH-1:0]      pc_q,         pc_d;
    logic [WIDTH-1:0]      rs1_data_q,   rs1_data_d;
    logic [WIDTH-1:0]      rs2_data_q,   rs2_data_d;
    logic [REG_ADDR_W-1:0] rs1_addr_q,   rs1_addr_d;
    logic [REG_ADDR_W-1:0] rs2_addr_q,   rs2_addr_d;
    logic [REG_ADDR_W-1:0] rd_addr_q,    rd_addr_d;
    logic [WIDTH-1:0]      imm_q,        imm_d;
    logic [ALU_CTRL_W-1:0] alu_ctrl_q,   alu_ctrl_d;
    logic                  alu_src_a_q,  alu_src_a_d;
    logic                  alu_src_b_q,  alu_src_b_d;
    logic                  reg_write_q,  reg_write_d;

    // Forwarded operand values, resolved on the registered source addresses
    logic [WIDTH-1:0]      rs1_fwd;
    logic [WIDTH-1:0]      rs2_fwd;
    logic                  code_illegal;

    fwd_mux #(
        .WIDTH      (WIDTH),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rs1 (
        .rs_addr_i      (rs1_addr_q),
        .rs_data_i      (rs1_data_q),
        .mem_regWrite_i (mem_regWrite_i),
        .mem_rd_addr_i  (mem_rd_addr_i),
        .mem_result_i   (mem_result_i),
        .wb_regWrite_i  (wb_regWrite_i),
        .wb_rd_addr_i   (wb_rd_addr_i),
        .wb_result_i    (wb_result_i),
        .data_o         (rs1_fwd)
    );

    fwd_mux #(
        .WIDTH      (WIDTH),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rs2 (
        .rs_addr_i      (rs2_addr_q),
        .rs_data_i      (rs2_data_q),
        .mem_regWrite_i (mem_regWrite_i),
        .mem_rd_addr_i  (mem_rd_addr_i),
        .mem_result_i   (mem_result_i),
        .wb_regWrite_i  (wb_regWrite_i),
        .wb_rd_addr_i   (wb_rd_addr_i),
        .wb_result_i    (wb_result_i),
        .data_o         (rs2_fwd)
    );

    // Next-state: flush beats stall, stall refreshes only the operand data, otherwise load.
    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        rs1_addr_d  = rs1_addr_q;
        rs2_addr_d  = rs2_addr_q;
        rd_addr_d   = rd_addr_q;
        imm_d       = imm_q;
        alu_ctrl_d  = alu_ctrl_q;
        alu_src_a_d = alu_src_a_q;
        alu_src_b_d = alu_src_b_q;
        reg_write_d = reg_write_q;

        if (flush_i) begin
            // Bubble: only the fields that can cause side effects need clearing.
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
        end else if (stall_i) begin
            // Fold any forwarded value into the held operands so it survives
            // the producer leaving the pipeline before the stall ends.
            rs1_data_d  = rs1_fwd;
            rs2_data_d  = rs2_fwd;
        end else begin
            valid_d     = id_valid_i;
            pc_d        = id_pc_i;
            rs1_data_d  = id_rs1_data_i;
            rs2_data_d  = id_rs2_data_i;
            rs1_addr_d  = id_rs1_addr_i;
            rs2_addr_d  = id_rs2_addr_i;
            rd_addr_d   = id_rd_addr_i;
            imm_d       = id_imm_i;
            alu_ctrl_d  = id_ALUControl_i;
            alu_src_a_d = id_aluSrcA_i;
            alu_src_b_d = id_aluSrcB_i;
            reg_write_d = id_regWrite_i;
        end
    end

    // Stage register with synchronous reset clearing every field.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values.
        if (rst_i) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rd_addr_q   <= '0;
            imm_q       <= '0;
            alu_ctrl_q  <= ALU_ADD;
            alu_src_a_q <= 1'b0;
            alu_src_b_q <= 1'b0;
            reg_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            rd_addr_q   <= rd_addr_d;
            imm_q       <= imm_d;
            alu_ctrl_q  <= alu_ctrl_d;
            alu_src_a_q <= alu_src_a_d;
            alu_src_b_q <= alu_src_b_d;
            reg_write_q <= reg_write_d;
        end
    end

    // Operand selection, ALU code sanitising and valid gating toward EX.
    always_comb begin
        code_illegal   = alu_code_illegal(alu_ctrl_q);
        srcA_o         = alu_src_a_q ? pc_q  : rs1_fwd;
        srcB_o         = alu_src_b_q ? imm_q : rs2_fwd;
        ex_storeData_o = rs2_fwd;
        // An unknown code must never reach the ALU, valid or not.
        ALUControl_o   = code_illegal ? ALU_ADD : alu_ctrl_q;
        illegal_o      = valid_q && code_illegal;
        ex_regWrite_o  = valid_q && reg_write_q;
        ex_valid_o     = valid_q;
        ex_rd_addr_o   = rd_addr_q;
        ex_pc_o        = pc_q;
    end

endmodule : alu_operand_stage
